// File: rtl/clk_div_n.sv
// Programmable clock-enable divider: one-in-N tick plus optional near-50% square wave.
// Define CLK_DIV_SQUARE_EN to build the square-wave output; otherwise sq is tied low.
module clk_div_n #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_ld,
  output logic         busy,
  output logic         q,
  output logic         sq
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pendValid_q, pendValid_d;
  logic         wrap;

  assign wrap = (cnt_q == (div_q - W'(1)));

  // A new divisor only replaces the active one on a wrap; a load in the same
  // cycle is applied after the wrap logic so it stays pending for the next boundary.
  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    if (en) begin
      if (wrap) begin
        cnt_d = '0;
        if (pendValid_q) begin
          div_d       = pend_q;
          pendValid_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
    if (div_ld) begin
      pend_d      = (div_in == '0) ? W'(1) : div_in;
      pendValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      div_q       <= W'(DEFAULT_DIV);
      pend_q      <= '0;
      pendValid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
    end
  end

  assign q    = (cnt_q == '0);
  assign busy = pendValid_q;

`ifdef CLK_DIV_SQUARE_EN
  // Halving at W+1 bits keeps div = 2^W-1 from overflowing when rounding up.
  logic [W:0] halfDiv;
  assign halfDiv = ({1'b0, div_q} + (W+1)'(1)) >> 1;
  assign sq      = ({1'b0, cnt_q} < halfDiv);
`else
  assign sq = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Directed self-checking bench for clk_div_n (W=8, DEFAULT_DIV=3).
module tb_clk_div_n;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] divIn;
  logic       divLd;
  logic       busy;
  logic       q;
  logic       sq;

  int testsRun    = 0;
  int testsFailed = 0;

  clk_div_n #(.W(8), .DEFAULT_DIV(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .div_in (divIn),
    .div_ld (divLd),
    .busy   (busy),
    .q      (q),
    .sq     (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square-wave expectation collapses to 0 when the square output is not built.
  function automatic logic sqExp(input logic v);
`ifdef CLK_DIV_SQUARE_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepClock(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [7:0] din);
    divLd = ld;
    divIn = din;
  endtask

  task automatic checkPattern(input string tag, input int n, input logic [31:0] qPat,
                              input logic [31:0] sqPat, input logic busyExp);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_q"}, q, qPat[n-1-i]);
      checkOutput({tag, "_sq"}, sq, sqExp(sqPat[n-1-i]));
      checkOutput({tag, "_busy"}, busy, busyExp);
      stepClock(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    applyStimulus(1'b0, 8'd0);
    stepClock(2);
    checkOutput("reset_q", q, 1);
    checkOutput("reset_sq", sq, sqExp(1'b1));
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;

    // Default divide-by-3: q 100, sq 110, two full periods.
    checkPattern("div3", 6, 32'b100100, 32'b110110, 1'b0);

    // Load 5 at cnt=1; applied at the wrap after cnt=2.
    stepClock(1);
    applyStimulus(1'b1, 8'd5);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    checkOutput("ld5_busy_pending", busy, 1);
    checkOutput("ld5_q_cnt2", q, 0);
    stepClock(1);
    checkPattern("div5", 5, 32'b10000, 32'b11100, 1'b0);
    checkOutput("div5_next_tick", q, 1);

    // Back-to-back loads 7 then 4: only 4 takes effect.
    applyStimulus(1'b1, 8'd7);
    stepClock(1);
    applyStimulus(1'b1, 8'd4);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    checkOutput("b2b_busy", busy, 1);
    stepClock(2);
    checkOutput("b2b_busy_cnt4", busy, 1);
    checkOutput("b2b_q_cnt4", q, 0);
    stepClock(1);
    checkPattern("div4", 4, 32'b1000, 32'b1100, 1'b0);
    checkOutput("div4_next_tick", q, 1);

    // div_in=0 is treated as 1: constant tick.
    applyStimulus(1'b1, 8'd0);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    stepClock(3);
    checkPattern("div0", 4, 32'b1111, 32'b1111, 1'b0);

    // div_in=1 while N=1: pending for one edge, then applied.
    applyStimulus(1'b1, 8'd1);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    checkOutput("div1_busy", busy, 1);
    checkOutput("div1_q_pending", q, 1);
    stepClock(1);
    checkPattern("div1", 3, 32'b111, 32'b111, 1'b0);

    // Maximum divisor 255: one tick, 128 sq-high cycles.
    applyStimulus(1'b1, 8'd255);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    stepClock(1);
    for (int i = 0; i < 255; i++) begin
      checkOutput("div255_q", q, (i == 0) ? 1 : 0);
      checkOutput("div255_sq", sq, sqExp(i < 128));
      stepClock(1);
    end
    checkOutput("div255_next_tick", q, 1);

    // Enable gating with N=5: hold at cnt=2 for 4 cycles, load captured while held.
    reset = 1'b1;
    stepClock(1);
    reset = 1'b0;
    applyStimulus(1'b1, 8'd5);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    stepClock(2);
    checkOutput("en_n5_start_q", q, 1);
    stepClock(2);
    en = 1'b0;
    applyStimulus(1'b1, 8'd5);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    checkOutput("en_hold_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("en_hold_q", q, 0);
      checkOutput("en_hold_sq", sq, sqExp(1'b1));
      stepClock(1);
    end
    en = 1'b1;
    checkOutput("en_hold_end_sq", sq, sqExp(1'b1));
    stepClock(1);
    checkOutput("en_cnt3_q", q, 0);
    checkOutput("en_cnt3_sq", sq, sqExp(1'b0));
    stepClock(1);
    checkOutput("en_cnt4_q", q, 0);
    checkOutput("en_cnt4_busy", busy, 1);
    stepClock(1);
    checkOutput("en_wrap_q", q, 1);
    checkOutput("en_wrap_busy", busy, 0);

    // Reset at cnt=3 with a load pending discards it and restores N=3.
    stepClock(2);
    applyStimulus(1'b1, 8'd7);
    stepClock(1);
    applyStimulus(1'b0, 8'd0);
    checkOutput("rst_pre_busy", busy, 1);
    checkOutput("rst_pre_q", q, 0);
    reset = 1'b1;
    stepClock(1);
    reset = 1'b0;
    checkPattern("rst_div3", 7, 32'b1001001, 32'b1101101, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
